// File: rtl/load_store_unit.sv
// Load/store unit: issues one word-wide data-memory access per request.
// Handles byte-lane steering, load extension, fault detection and an ack timeout.
module load_store_unit #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  req_valid_i,
   input  logic                  mem_write_i,
   input  logic [1:0]            mem_mode_i,
   input  logic                  load_unsigned_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [31:0]           wdata_i,
   output logic                  stall_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [31:0]           rdata_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [3:0]            mem_be_o,
   output logic [31:0]           mem_wdata_o,
   input  logic                  mem_ack_i,
   input  logic [31:0]           mem_rdata_i
);

   localparam logic [1:0] ModeByte = 2'b00;
   localparam logic [1:0] ModeHalf = 2'b01;
   localparam logic [1:0] ModeWord = 2'b10;

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   // Counter value seen in the last REQ cycle allowed before giving up.
   localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

   state_e          state_q;
   logic [1:0]      mode_q;
   logic            write_q;
   logic            unsigned_q;
   logic [1:0]      off_q;
   logic [CntW-1:0] cnt_q;

   function automatic logic access_ok(input logic [1:0] mode, input logic [1:0] off);
      logic ok;
      case (mode)
         ModeByte: ok = 1'b1;
         ModeHalf: ok = ~off[0];
         ModeWord: ok = (off == 2'b00);
         default:  ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [3:0] lane_enables(input logic [1:0] mode, input logic [1:0] off);
      logic [3:0] be;
      case (mode)
         ModeByte: be = 4'b0001 << off;
         ModeHalf: be = off[1] ? 4'b1100 : 4'b0011;
         default:  be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [1:0] mode, input logic [31:0] wd);
      logic [31:0] d;
      case (mode)
         ModeByte: d = {4{wd[7:0]}};
         ModeHalf: d = {2{wd[15:0]}};
         default:  d = wd;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] mode,
                                               input logic [1:0] off, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (mode)
         ModeByte: r = {{24{~uns & b[7]}}, b};
         ModeHalf: r = {{16{~uns & h[15]}}, h};
         default:  r = word;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         mode_q      <= 2'b00;
         write_q     <= 1'b0;
         unsigned_q  <= 1'b0;
         off_q       <= 2'b00;
         cnt_q       <= '0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         rdata_o     <= 32'h0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_be_o    <= 4'b0000;
         mem_wdata_o <= 32'h0;
      end else begin
         done_o <= 1'b0;
         case (state_q)
            StIdle: begin
               if (req_valid_i) begin
                  mode_q     <= mem_mode_i;
                  write_q    <= mem_write_i;
                  unsigned_q <= load_unsigned_i;
                  off_q      <= addr_i[1:0];
                  cnt_q      <= '0;
                  if (access_ok(mem_mode_i, addr_i[1:0])) begin
                     state_q     <= StReq;
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= mem_write_i;
                     mem_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                     mem_be_o    <= lane_enables(mem_mode_i, addr_i[1:0]);
                     mem_wdata_o <= lane_wdata(mem_mode_i, wdata_i);
                  end else begin
                     // Faults never touch the bus.
                     state_q <= StDone;
                     done_o  <= 1'b1;
                     err_o   <= 1'b1;
                     rdata_o <= 32'h0;
                  end
               end
            end
            StReq: begin
               if (mem_ack_i) begin
                  state_q   <= StDone;
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  done_o    <= 1'b1;
                  err_o     <= 1'b0;
                  rdata_o   <= write_q ? 32'h0
                                       : extend_load(mem_rdata_i, mode_q, off_q, unsigned_q);
               end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TimeoutLast)) begin
                  state_q   <= StDone;
                  mem_req_o <= 1'b0;
                  mem_we_o  <= 1'b0;
                  done_o    <= 1'b1;
                  err_o     <= 1'b1;
                  rdata_o   <= 32'h0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StDone: state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

   // Stall asserts combinationally in IDLE so the request cycle itself is held.
   always_comb begin
      stall_o = 1'b0;
      case (state_q)
         StIdle:  stall_o = req_valid_i;
         StReq:   stall_o = 1'b1;
         default: stall_o = 1'b0;
      endcase
   end

endmodule
